// File: rtl/issue_arbiter_if.sv
// Issue-queue request/grant handshake and CDB-select outputs of the issue arbiter.
interface issue_arbiter_if #(
    parameter int W = 8
);
    logic         int_ready;
    logic         ls_ready;
    logic         mul_ready;
    logic         div_ready;
    logic         int_issue;
    logic         ls_issue;
    logic         mul_issue;
    logic         div_issue;
    logic         div_busy;
    logic         cdb_sel_valid;
    logic [1:0]   cdb_sel;
    logic [W-1:0] cdb_rsv;

    modport master (
        output int_ready, ls_ready, mul_ready, div_ready,
        input  int_issue, ls_issue, mul_issue, div_issue,
        input  div_busy, cdb_sel_valid, cdb_sel, cdb_rsv
    );

    modport slave (
        input  int_ready, ls_ready, mul_ready, div_ready,
        output int_issue, ls_issue, mul_issue, div_issue,
        output div_busy, cdb_sel_valid, cdb_sel, cdb_rsv
    );
endinterface

// File: rtl/issue_arbiter.sv
// Single-issue LRU scheduler over four issue queues with CDB slot reservation
// and non-pipelined divider tracking.
module issue_arbiter #(
    parameter int LS_LAT  = 2,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 8
) (
    input  logic          clk,
    input  logic          reset,
    issue_arbiter_if.slave bus
);
    localparam int W  = DIV_LAT;
    localparam int CW = $clog2(DIV_LAT);

    typedef enum logic [1:0] {ID_INT = 2'd0, ID_LS = 2'd1, ID_MUL = 2'd2, ID_DIV = 2'd3} unit_e;

    logic [W-1:0]  rsv, rsv_c;
    unit_e         own   [W];
    unit_e         own_c [W];
    unit_e         lru   [4];
    unit_e         lru_n [4];
    logic [CW-1:0] div_cnt;
    logic          div_busy;
    logic [3:0]    elig;
    logic [3:0]    grant;
    logic          gnt_any;
    unit_e         gnt_id;
    logic [1:0]    gnt_pos;
    logic          cdb_v;
    unit_e         cdb_id;

    assign div_busy = (div_cnt != '0);

    assign elig[0] = bus.int_ready & ~rsv[0];
    assign elig[1] = bus.ls_ready  & ~rsv[LS_LAT-1];
    assign elig[2] = bus.mul_ready & ~rsv[MUL_LAT-1];
    assign elig[3] = bus.div_ready & ~rsv[DIV_LAT-1] & ~div_busy;

    // First eligible entry in LRU order wins; reset masks the grant.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = ID_INT;
        gnt_pos = 2'd0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!gnt_any && elig[lru[i]]) begin
                gnt_any = 1'b1;
                gnt_id  = lru[i];
                gnt_pos = i[1:0];
            end
        end
        if (reset) gnt_any = 1'b0;
        grant = gnt_any ? (4'b0001 << gnt_id) : 4'b0000;
    end

    // Entries behind the granted one slide up; the granted ID goes to the tail.
    always_comb begin
        for (int unsigned i = 0; i < 3; i++) begin
            lru_n[i] = (gnt_any && (i >= 32'(gnt_pos))) ? lru[i+1] : lru[i];
        end
        lru_n[3] = gnt_any ? gnt_id : lru[3];
    end

    always_comb begin
        rsv_c = rsv;
        for (int unsigned k = 0; k < W; k++) own_c[k] = own[k];
        if (gnt_any) begin
            case (gnt_id)
                ID_INT: begin rsv_c[0]         = 1'b1; own_c[0]         = ID_INT; end
                ID_LS:  begin rsv_c[LS_LAT-1]  = 1'b1; own_c[LS_LAT-1]  = ID_LS;  end
                ID_MUL: begin rsv_c[MUL_LAT-1] = 1'b1; own_c[MUL_LAT-1] = ID_MUL; end
                default: begin rsv_c[DIV_LAT-1] = 1'b1; own_c[DIV_LAT-1] = ID_DIV; end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsv     <= '0;
            for (int unsigned k = 0; k < W; k++) own[k] <= ID_INT;
            lru[0]  <= ID_INT;
            lru[1]  <= ID_LS;
            lru[2]  <= ID_MUL;
            lru[3]  <= ID_DIV;
            cdb_v   <= 1'b0;
            cdb_id  <= ID_INT;
            div_cnt <= '0;
        end else begin
            rsv <= rsv_c >> 1;
            for (int unsigned k = 0; k < W - 1; k++) own[k] <= own_c[k+1];
            own[W-1] <= ID_INT;
            cdb_v    <= rsv_c[0];
            cdb_id   <= own_c[0];
            for (int unsigned i = 0; i < 4; i++) lru[i] <= lru_n[i];
            if (grant[3])     div_cnt <= CW'(DIV_LAT - 1);
            else if (div_busy) div_cnt <= div_cnt - 1'b1;
        end
    end

    assign bus.int_issue     = grant[0];
    assign bus.ls_issue      = grant[1];
    assign bus.mul_issue     = grant[2];
    assign bus.div_issue     = grant[3];
    assign bus.div_busy      = div_busy;
    assign bus.cdb_sel_valid = cdb_v;
    assign bus.cdb_sel       = cdb_id;
    assign bus.cdb_rsv       = rsv;
endmodule
